// File: rtl/matrix_kxk_pkg.sv
// Shared constants and the flattened-window tap index helper.
package matrix_pkg;
   localparam int BORDER_ZERO = 0;
   localparam int BORDER_REPL = 1;
   localparam int COORD_W     = 11;

   // Tap (r,c) occupies slot r*k+c of the flattened window bus.
   function automatic int tap_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction
endpackage

// File: rtl/matrix_kxk_line_buffer.sv
// Simple dual-port line memory with a registered read port.
module line_buffer
   import matrix_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 640,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              re,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/matrix_kxk.sv
// KxK sliding-window generator: line-buffer read stage, then column shift
// with border masking/replication into a registered window output.
module matrix_kxk
   import matrix_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int KSIZE       = 3,
   parameter int BORDER_MODE = BORDER_ZERO
) (
   input  logic                          video_clk,
   input  logic                          rst,
   input  logic                          video_vs,
   input  logic                          video_de,
   input  logic [DATA_W-1:0]             video_data,
   output logic                          matrix_de,
   output logic                          matrix_vs,
   output logic [COORD_W-1:0]            matrix_x,
   output logic [COORD_W-1:0]            matrix_y,
   output logic [KSIZE*KSIZE*DATA_W-1:0] matrix_data
);
   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int NB = KSIZE - 1;
   localparam int IW = $clog2(KSIZE);

   if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
      $error("matrix_kxk: KSIZE must be 3 or 5");
   end

   logic                          vs_q, vs_edge;
   logic [COORD_W-1:0]            x, y, px, py;
   logic                          vld_p0, vs_p0;
   logic [COORD_W-1:0]            x_p0, y_p0;
   logic [DATA_W-1:0]             pix_p0;
   logic [DATA_W-1:0]             rd     [NB];
   logic [DATA_W-1:0]             lb_in  [NB];
   logic [DATA_W-1:0]             row_in [KSIZE];
   logic [DATA_W-1:0]             col    [KSIZE][KSIZE-1];
   logic [DATA_W-1:0]             win    [KSIZE][KSIZE];
   logic [KSIZE*KSIZE*DATA_W-1:0] data_next;
   logic [IW-1:0]                 rr, cc;
   logic                          row_out, col_out;
   logic [DATA_W-1:0]             tap;

   // A vs rising edge overrides the running counters for the pixel arriving with it.
   assign vs_edge = video_vs & ~vs_q;
   assign px      = vs_edge ? '0 : x;
   assign py      = vs_edge ? '0 : y;

   always_ff @(posedge video_clk) begin
      if (rst) begin
         vs_q <= 1'b0;
         x    <= '0;
         y    <= '0;
      end else begin
         vs_q <= video_vs;
         if (video_de) begin
            if (px == COORD_W'(IMG_WIDTH - 1)) begin
               x <= '0;
               y <= (py == COORD_W'(IMG_HEIGHT - 1)) ? '0 : py + 1'b1;
            end else begin
               x <= px + 1'b1;
               y <= py;
            end
         end else if (vs_edge) begin
            x <= '0;
            y <= '0;
         end
      end
   end

   // Stage p0: pixel and coordinates registered while the line buffers read.
   always_ff @(posedge video_clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vs_p0  <= 1'b0;
         x_p0   <= '0;
         y_p0   <= '0;
      end else begin
         vld_p0 <= video_de;
         vs_p0  <= video_vs;
         if (video_de) begin
            x_p0 <= px;
            y_p0 <= py;
         end
      end
   end

   always_ff @(posedge video_clk) begin
      if (video_de) pix_p0 <= video_data;
   end

   for (genvar i = 0; i < NB; i++) begin : g_lb
      if (i == 0) begin : g_first
         assign lb_in[i] = pix_p0;
      end else begin : g_next
         assign lb_in[i] = rd[i-1];
      end
      line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_WIDTH), .AW(AW)) u_lb (
         .clk    (video_clk),
         .we     (vld_p0),
         .wr_addr(x_p0[AW-1:0]),
         .wr_data(lb_in[i]),
         .re     (video_de),
         .rd_addr(px[AW-1:0]),
         .rd_data(rd[i])
      );
   end

   assign row_in[KSIZE-1] = pix_p0;
   for (genvar r = 0; r < NB; r++) begin : g_row
      assign row_in[r] = rd[NB-1-r];
   end

   always_comb begin
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE - 1; c++) win[r][c] = col[r][c];
         win[r][KSIZE-1] = row_in[r];
      end
   end

   // Out-of-image taps either zero or fold back onto row/column 0 of this frame.
   always_comb begin
      data_next = '0;
      rr        = '0;
      cc        = '0;
      row_out   = 1'b0;
      col_out   = 1'b0;
      tap       = '0;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            row_out = int'(y_p0) < (KSIZE - 1 - r);
            col_out = int'(x_p0) < (KSIZE - 1 - c);
            rr = row_out ? IW'(KSIZE - 1 - int'(y_p0)) : IW'(r);
            cc = col_out ? IW'(KSIZE - 1 - int'(x_p0)) : IW'(c);
            if (BORDER_MODE == BORDER_REPL) tap = win[rr][cc];
            else                            tap = (row_out || col_out) ? '0 : win[r][c];
            data_next[tap_idx(r, c, KSIZE)*DATA_W +: DATA_W] = tap;
         end
      end
   end

   // Stage p1: column shift registers advance and the bordered window is registered.
   always_ff @(posedge video_clk) begin
      if (vld_p0) begin
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE - 1; c++) col[r][c] <= win[r][c+1];
      end
   end

   always_ff @(posedge video_clk) begin
      if (rst) begin
         matrix_de   <= 1'b0;
         matrix_vs   <= 1'b0;
         matrix_x    <= '0;
         matrix_y    <= '0;
         matrix_data <= '0;
      end else begin
         matrix_de <= vld_p0;
         matrix_vs <= vs_p0;
         if (vld_p0) begin
            matrix_x    <= x_p0;
            matrix_y    <= y_p0;
            matrix_data <= data_next;
         end
      end
   end
endmodule

// File: tb/tb_matrix_kxk.sv
// Bench for matrix_kxk: three configurations share one 5x5 raster stream and a scoreboard.
module tb_matrix_kxk;
   import matrix_pkg::*;

   localparam int W = 5;
   localparam int H = 5;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       vs   = 1'b0;
   logic       de   = 1'b0;
   logic [7:0] data = '0;

   logic        de_a, vs_a, de_b, vs_b, de_c, vs_c;
   logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
   logic [71:0]  d_a, d_b;
   logic [199:0] d_c;

   always #5 clk = ~clk;

   matrix_kxk #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(3), .BORDER_MODE(BORDER_ZERO)) dut_a (
      .video_clk(clk), .rst(rst), .video_vs(vs), .video_de(de), .video_data(data),
      .matrix_de(de_a), .matrix_vs(vs_a), .matrix_x(x_a), .matrix_y(y_a), .matrix_data(d_a));

   matrix_kxk #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(3), .BORDER_MODE(BORDER_REPL)) dut_b (
      .video_clk(clk), .rst(rst), .video_vs(vs), .video_de(de), .video_data(data),
      .matrix_de(de_b), .matrix_vs(vs_b), .matrix_x(x_b), .matrix_y(y_b), .matrix_data(d_b));

   matrix_kxk #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .KSIZE(5), .BORDER_MODE(BORDER_ZERO)) dut_c (
      .video_clk(clk), .rst(rst), .video_vs(vs), .video_de(de), .video_data(data),
      .matrix_de(de_c), .matrix_vs(vs_c), .matrix_x(x_c), .matrix_y(y_c), .matrix_data(d_c));

   typedef struct {
      int x;
      int y;
      int off;
      int due;
   } item_t;

   item_t        sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   logic         vs_d1  = 1'b0;
   logic [199:0] last_exp [3];

   function automatic logic [7:0] pix(input int x, input int y, input int off);
      return 8'(y * W + x + 1 + off);
   endfunction

   // Reference window straight from the image definition.
   function automatic logic [199:0] exp_win(input int k, input int mode, input int x, input int y, input int off);
      logic [199:0] w;
      int           yy, xx;
      logic [7:0]   v;
      w = '0;
      for (int r = 0; r < k; r++) begin
         for (int c = 0; c < k; c++) begin
            yy = y - (k - 1) + r;
            xx = x - (k - 1) + c;
            if (yy < 0 || xx < 0)
               v = (mode == BORDER_REPL) ? pix((xx < 0) ? 0 : xx, (yy < 0) ? 0 : yy, off) : 8'h00;
            else
               v = pix(xx, yy, off);
            w[(r * k + c) * 8 +: 8] = v;
         end
      end
      return w;
   endfunction

   task automatic chk_dut(input string tag, input int idx, input int k, input int mode,
                          input logic de_o, input logic vs_o, input logic [10:0] x_o,
                          input logic [10:0] y_o, input logic [199:0] d_o,
                          input bit have, input logic exp_vs, input bit in_rst);
      logic [10:0] ex, ey;
      checks++;
      assert (de_o === logic'(have)) else begin
         errors++; $error("FAIL %s matrix_de got %b want %b (cyc %0d)", tag, de_o, have, cyc);
      end
      checks++;
      assert (vs_o === exp_vs) else begin
         errors++; $error("FAIL %s matrix_vs got %b want %b (cyc %0d)", tag, vs_o, exp_vs, cyc);
      end
      if (have || in_rst) begin
         ex = have ? 11'(sb[0].x) : 11'd0;
         ey = have ? 11'(sb[0].y) : 11'd0;
         if (have) last_exp[idx] = exp_win(k, mode, sb[0].x, sb[0].y, sb[0].off);
         checks++;
         assert ({x_o, y_o} === {ex, ey}) else begin
            errors++; $error("FAIL %s xy got (%0d,%0d) want (%0d,%0d)", tag, x_o, y_o, ex, ey);
         end
      end
      checks++;
      assert (d_o === last_exp[idx]) else begin
         errors++; $error("FAIL %s matrix_data got %h want %h (cyc %0d)", tag, d_o, last_exp[idx], cyc);
      end
   endtask

   task automatic step(input bit r, input bit v, input bit d, input int px, input int py, input int off);
      item_t it;
      bit    have;
      logic  exp_vs;
      rst  = r;
      vs   = v;
      de   = d;
      data = d ? pix(px, py, off) : 8'($urandom);
      if (d && !r) begin
         it.x = px; it.y = py; it.off = off; it.due = cyc + 2;
         sb.push_back(it);
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_vs = r ? 1'b0 : vs_d1;
      vs_d1  = r ? 1'b0 : v;
      if (r) begin
         sb.delete();
         for (int i = 0; i < 3; i++) last_exp[i] = '0;
      end
      have = (sb.size() > 0) && (sb[0].due == cyc);
      chk_dut("k3_zero", 0, 3, BORDER_ZERO, de_a, vs_a, x_a, y_a, 200'(d_a), have, exp_vs, r);
      chk_dut("k3_repl", 1, 3, BORDER_REPL, de_b, vs_b, x_b, y_b, 200'(d_b), have, exp_vs, r);
      chk_dut("k5_zero", 2, 5, BORDER_ZERO, de_c, vs_c, x_c, y_c, d_c, have, exp_vs, r);
      if (have) void'(sb.pop_front());
   endtask

   // 5-on/6-off raster; vs held high for the first two pixels when requested.
   task automatic send_pixels(input int off, input int count, input bit vs_start, input int gap_at);
      int x, y;
      for (int k = 0; k < count; k++) begin
         x = k % W;
         y = (k / W) % H;
         step(1'b0, vs_start && (k < 2), 1'b1, x, y, off);
         if (k == gap_at) begin
            step(1'b0, 1'b0, 1'b0, 0, 0, 0);
            step(1'b0, 1'b0, 1'b0, 0, 0, 0);
         end
         if (x == W - 1)
            for (int g = 0; g < 6; g++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) last_exp[i] = '0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      send_pixels(0, W * H, 1'b0, -1);
      send_pixels(100, 13, 1'b1, -1);
      for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      send_pixels(50, 8, 1'b1, -1);
      step(1'b1, 1'b0, 1'b1, 3, 1, 50);
      step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      send_pixels(200, W * H, 1'b0, 12);
      send_pixels(150, 10, 1'b0, -1);
      for (int g = 0; g < 4; g++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      checks++;
      assert (sb.size() == 0) else begin
         errors++; $error("FAIL scoreboard_drain left %0d want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
